led_cycle: RTL and testbench

LED_CYCLE -- requirements
Module: led_cycle

---
 rtl/led_cycle.sv | 94 +++++++++
 tb/tb_led_cycle.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/led_cycle.sv
// led_cycle: a one-hot running light on 16 LEDs with five selectable step rates.
// Five push-buttons pick the rate. The highest pressed button wins, and with no
// button pressed the slowest rate (DIV0) is used. The buttons are asynchronous,
// so each one passes through a two-flop synchronizer before anything uses it.
// The step counter is never cleared when the rate changes. Speeding up can
// therefore cause an immediate step, and slowing down simply lengthens the
// interval that is already running.
// Every DIVn must be an integer >= 1.

module led_cycle #(
  parameter int unsigned DIV0 = 25_000_000,
  parameter int unsigned DIV1 = 12_500_000,
  parameter int unsigned DIV2 = 6_250_000,
  parameter int unsigned DIV3 = 3_125_000,
  parameter int unsigned DIV4 = 1_562_500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  buttons,
  output logic [15:0] led
);

  // The counter must hold values up to the largest DIVn - 1.
  localparam int unsigned MAX01   = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned MAX23   = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned MAX0123 = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int unsigned DIV_MAX = (MAX0123 > DIV4) ? MAX0123 : DIV4;
  localparam int unsigned CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  // Each limit is the terminal count for its rate, i.e. DIVn - 1.
  localparam logic [CNT_W-1:0] LIM0 = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] LIM1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] LIM2 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] LIM3 = CNT_W'(DIV3 - 1);
  localparam logic [CNT_W-1:0] LIM4 = CNT_W'(DIV4 - 1);

  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_led;

  logic [CNT_W-1:0] w_lim;
  logic             w_step;
  logic [CNT_W-1:0] w_cnt_next;
  logic [15:0]      w_led_next;

  // Two-flop synchronizer that brings the asynchronous buttons into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 5'b00000;
      r_sync2 <= 5'b00000;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
    end
  end

  // Priority select of the terminal count: the highest synchronized button wins, and no button selects DIV0.
  always_comb begin
    w_lim = LIM0;
    if (r_sync2[4])      w_lim = LIM4;
    else if (r_sync2[3]) w_lim = LIM3;
    else if (r_sync2[2]) w_lim = LIM2;
    else if (r_sync2[1]) w_lim = LIM1;
    else                 w_lim = LIM0;
  end

  // Step decision and next counter value. A count that is already past the limit
  // (left over after a switch to a faster rate) also triggers a step.
  always_comb begin
    w_step     = (r_cnt >= w_lim);
    w_cnt_next = w_step ? '0 : (r_cnt + CNT_W'(1));
  end

  // Rotate-left of the running light, so 16'h8000 wraps to 16'h0001.
  always_comb begin
    w_led_next = r_led;
    if (w_step) w_led_next = {r_led[14:0], r_led[15]};
  end

  // Counter and LED state. Reset takes priority over a coincident step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_led <= 16'h0001;
    end else begin
      r_cnt <= w_cnt_next;
      r_led <= w_led_next;
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_led_cycle.sv
// tb_led_cycle: scoreboard bench for led_cycle with DIV0..DIV4 = 16, 8, 4, 2, 1.
// For every clock edge, a behavioural reference pushes the expected LED word.
// The bench pops that word after the edge and compares it with the DUT. Directed
// period measurements sit on top of this scoreboard.

module tb_led_cycle;

  logic        clk;
  logic        rst_n;
  logic [4:0]  buttons;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  // reference state
  logic [4:0]  m_s1, m_s2;
  int          m_cnt;
  logic [15:0] m_led;
  logic [4:0]  cur_btn;

  led_cycle #(
    .DIV0(16), .DIV1(8), .DIV2(4), .DIV3(2), .DIV4(1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .buttons(buttons),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int period_of(input logic [4:0] s);
    if (s[4]) return 1;
    if (s[3]) return 2;
    if (s[2]) return 4;
    if (s[1]) return 8;
    return 16;
  endfunction

  // One clock edge: drive the inputs, predict the result, then compare after the edge.
  task automatic tick(input logic rn, input logic [4:0] b);
    logic [15:0] e;
    rst_n   = rn;
    buttons = b;
    if (!rn) begin
      m_led = 16'h0001;
      m_cnt = 0;
      m_s1  = '0;
      m_s2  = '0;
    end else begin
      if (m_cnt >= period_of(m_s2) - 1) begin
        m_cnt = 0;
        m_led = {m_led[14:0], m_led[15]};
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    exp_q.push_back(m_led);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("led", led, e);
    check_eq("onehot", $onehot(led), 1);
  endtask

  // Count the edges until the LED changes. The wait is bounded.
  task automatic wait_step(output int n);
    logic [15:0] prev;
    prev = led;
    n = 0;
    while (led === prev && n < 64) begin
      tick(1'b1, cur_btn);
      n++;
    end
    if (led === prev) check_eq("step_timeout", n, 0);
  endtask

  // Apply a new button pattern, let it propagate, and align on a step edge.
  task automatic settle(input logic [4:0] b);
    int n;
    cur_btn = b;
    repeat (3) tick(1'b1, cur_btn);
    wait_step(n);
  endtask

  task automatic measure(input string tag, input int exp_period);
    int n;
    wait_step(n);
    check_eq(tag, n, exp_period);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    buttons = 5'b00000;
    cur_btn = 5'b00000;
    m_s1 = '0; m_s2 = '0; m_cnt = 0; m_led = 16'h0001;

    // reset
    repeat (3) tick(1'b0, 5'b00000);
    check_eq("rst_led", led, 16'h0001);

    // release with no buttons: first step after 16 cycles
    wait_step(n);
    check_eq("first_step", n, 16);
    check_eq("first_led", led, 16'h0002);
    measure("per16", 16);

    // wrap at the fastest rate
    settle(5'b10000);
    n = 0;
    while (led !== 16'h8000 && n < 64) begin
      tick(1'b1, cur_btn);
      n++;
    end
    check_eq("reach_8000", led, 16'h8000);
    tick(1'b1, cur_btn);
    check_eq("wrap", led, 16'h0001);

    // rate selection by single buttons
    settle(5'b00010); measure("per8", 8);
    settle(5'b00100); measure("per4", 4);
    settle(5'b01000); measure("per2", 2);
    settle(5'b10000); measure("per1", 1);
    settle(5'b10001); measure("per1_prio", 1);
    settle(5'b00000); measure("per16_back", 16);

    // switch to the fastest rate with the counter at 10
    settle(5'b00001);
    repeat (8) tick(1'b1, cur_btn);
    cur_btn = 5'b10000;
    wait_step(n);
    check_eq("switch_latency", n, 3);
    measure("after_switch", 1);

    // reset mid-interval at led = 0x0040
    settle(5'b00000);
    n = 0;
    while (led !== 16'h0040 && n < 300) begin
      tick(1'b1, cur_btn);
      n++;
    end
    check_eq("reach_0040", led, 16'h0040);
    repeat (5) tick(1'b1, cur_btn);
    tick(1'b0, cur_btn);
    check_eq("mid_rst_led", led, 16'h0001);
    wait_step(n);
    check_eq("mid_rst_period", n, 16);
    check_eq("mid_rst_next", led, 16'h0002);
    measure("mid_rst_per16", 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
